// File: rtl/tetris_stats_pkg.sv
// Shared types, BCD constants and helpers for the game statistics block.
package tetris_stats_pkg;

  typedef logic [23:0] bcd6_t;

  localparam bcd6_t BCD6_MAX = 24'h999999;
  localparam bcd6_t PTS_1    = 24'h000040;
  localparam bcd6_t PTS_2    = 24'h000100;
  localparam bcd6_t PTS_3    = 24'h000300;
  localparam bcd6_t PTS_4    = 24'h001200;

  typedef enum logic [1:0] {IDLE, SCORE, LINES} stats_state_t;

  function automatic bcd6_t pts_for(input logic [2:0] n);
    case (n)
      3'd1:    return PTS_1;
      3'd2:    return PTS_2;
      3'd3:    return PTS_3;
      3'd4:    return PTS_4;
      default: return '0;
    endcase
  endfunction

  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic bcd6_t bin5_to_bcd(input logic [4:0] v);
    logic [3:0] tens;
    logic [4:0] ones;
    tens = '0;
    ones = v;
    for (int i = 0; i < 3; i++) begin
      if (ones >= 5'd10) begin
        ones = ones - 5'd10;
        tens = tens + 4'd1;
      end
    end
    return {16'h0, tens, ones[3:0]};
  endfunction

endpackage

// File: rtl/game_stats_bcd_add6.sv
// Combinational 6-digit packed-BCD adder; carry_o flags overflow past digit 5.
module bcd_add6
  import tetris_stats_pkg::*;
(
  input  bcd6_t a,
  input  bcd6_t b,
  output bcd6_t sum,
  output logic  carry_o
);

  logic [4:0] d;
  logic       c;

  always_comb begin
    d   = '0;
    c   = 1'b0;
    sum = '0;
    for (int i = 0; i < 6; i++) begin
      d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
      if (d > 5'd9) begin
        d = d + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      sum[4*i +: 4] = d[3:0];
    end
    carry_o = c;
  end

endmodule

// File: rtl/game_stats.sv
// Score/lines/level tracker with serial BCD scoring (points x (level+1)).
// Optional soft-drop bonus input enabled by defining GAME_STATS_DROP_BONUS_EN.
module game_stats
  import tetris_stats_pkg::*;
#(
  parameter int unsigned LINES_PER_LEVEL = 10,
  parameter int unsigned START_LEVEL     = 0,
  parameter int unsigned MAX_LEVEL       = 99
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        new_game_i,
  input  logic        clr_valid_i,
  input  logic [2:0]  clr_lines_i,
`ifdef GAME_STATS_DROP_BONUS_EN
  input  logic        drop_valid_i,
  input  logic [4:0]  drop_rows_i,
`endif
  output logic        clr_ready_o,
  output logic [23:0] gd_score_o,
  output logic [23:0] gd_lines_o,
  output logic [23:0] gd_level_o,
  output logic        level_up_o
);

  localparam logic [6:0] START_BIN = 7'(START_LEVEL);
  localparam logic [7:0] START_BCD = {4'(START_LEVEL / 10), 4'(START_LEVEL % 10)};

  stats_state_t state;
  bcd6_t        score, lines, base;
  logic [2:0]   n_q;
  logic [6:0]   mult_cnt, level_bin;
  logic [7:0]   level_bcd;
  logic [3:0]   in_lvl;
  logic         level_up;

  logic         accept;
  logic [2:0]   n_clamp;
  bcd6_t        score_b, score_sum, lines_sum;
  logic         score_co, lines_co;
  logic [4:0]   in_sum, in_wrap;
  logic         wrap;

  assign clr_ready_o = (state == IDLE) && !new_game_i;
  assign accept      = clr_valid_i && clr_ready_o;
  assign n_clamp     = (clr_lines_i > 3'd4) ? 3'd4 : clr_lines_i;

`ifdef GAME_STATS_DROP_BONUS_EN
  assign score_b = (state == IDLE) ? bin5_to_bcd(drop_rows_i) : base;
`else
  assign score_b = base;
`endif

  bcd_add6 u_score_add (.a(score), .b(score_b),         .sum(score_sum), .carry_o(score_co));
  bcd_add6 u_lines_add (.a(lines), .b({21'h0, n_q}),    .sum(lines_sum), .carry_o(lines_co));

  assign in_sum  = {1'b0, in_lvl} + {2'b0, n_q};
  assign in_wrap = in_sum - 5'(LINES_PER_LEVEL);
  assign wrap    = in_sum >= 5'(LINES_PER_LEVEL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      score     <= '0;
      lines     <= '0;
      base      <= '0;
      n_q       <= '0;
      mult_cnt  <= '0;
      level_bin <= START_BIN;
      level_bcd <= START_BCD;
      in_lvl    <= '0;
      level_up  <= 1'b0;
    end else if (new_game_i) begin
      state     <= IDLE;
      score     <= '0;
      lines     <= '0;
      base      <= '0;
      n_q       <= '0;
      mult_cnt  <= '0;
      level_bin <= START_BIN;
      level_bcd <= START_BCD;
      in_lvl    <= '0;
      level_up  <= 1'b0;
    end else begin
      level_up <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && n_clamp != 3'd0) begin
            base     <= pts_for(n_clamp);
            n_q      <= n_clamp;
            mult_cnt <= level_bin + 7'd1;
            state    <= SCORE;
          end
`ifdef GAME_STATS_DROP_BONUS_EN
          else if (drop_valid_i && !accept) begin
            score <= score_co ? BCD6_MAX : score_sum;
          end
`endif
        end
        SCORE: begin
          score    <= score_co ? BCD6_MAX : score_sum;
          mult_cnt <= mult_cnt - 7'd1;
          if (mult_cnt == 7'd1) state <= LINES;
        end
        LINES: begin
          lines  <= lines_co ? BCD6_MAX : lines_sum;
          in_lvl <= wrap ? in_wrap[3:0] : in_sum[3:0];
          // Level holds at the ceiling but the in-level counter keeps wrapping.
          if (wrap && level_bin < 7'(MAX_LEVEL)) begin
            level_bin <= level_bin + 7'd1;
            level_bcd <= bcd2_inc(level_bcd);
            level_up  <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gd_score_o = score;
  assign gd_lines_o = lines;
  assign gd_level_o = {16'h0, level_bcd};
  assign level_up_o = level_up;

endmodule

// File: tb/tb_game_stats.sv
// Scoreboard bench for game_stats: three instances at start levels 0, 2 and 99.
module tb_game_stats;
  import tetris_stats_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ng[3];
  logic        vld[3];
  logic [2:0]  nl[3];
  logic        rdy[3];
  logic [23:0] sc[3], ln[3], lv[3];
  logic        lu[3];

  always #5 clk = ~clk;

  game_stats #(.START_LEVEL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .new_game_i(ng[0]), .clr_valid_i(vld[0]), .clr_lines_i(nl[0]),
    .clr_ready_o(rdy[0]), .gd_score_o(sc[0]), .gd_lines_o(ln[0]), .gd_level_o(lv[0]),
    .level_up_o(lu[0]));
  game_stats #(.START_LEVEL(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .new_game_i(ng[1]), .clr_valid_i(vld[1]), .clr_lines_i(nl[1]),
    .clr_ready_o(rdy[1]), .gd_score_o(sc[1]), .gd_lines_o(ln[1]), .gd_level_o(lv[1]),
    .level_up_o(lu[1]));
  game_stats #(.START_LEVEL(99)) dut2 (
    .clk(clk), .rst_n(rst_n), .new_game_i(ng[2]), .clr_valid_i(vld[2]), .clr_lines_i(nl[2]),
    .clr_ready_o(rdy[2]), .gd_score_o(sc[2]), .gd_lines_o(ln[2]), .gd_level_o(lv[2]),
    .level_up_o(lu[2]));

  typedef struct {
    logic [23:0] score;
    logic [23:0] lines;
    logic [23:0] level;
    int          busy;
    int          lvlups;
  } exp_t;

  exp_t exp_q[$];
  int   sel = 0;
  int   n_pass = 0;
  int   n_chk = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endfunction

  function automatic logic [23:0] to_bcd(int v);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Monitor: on each accepted event, time the busy window, then compare against the queue head.
  initial begin
    exp_t        e;
    int          busy, lu_cnt;
    logic [23:0] s_sc, s_ln, s_lv;
    forever begin
      @(negedge clk);
      if (rst_n && vld[sel] && rdy[sel]) begin
        busy   = 0;
        lu_cnt = 0;
        @(negedge clk);
        while (!rdy[sel] && busy < 300) begin
          busy++;
          if (lu[sel]) lu_cnt++;
          @(negedge clk);
        end
        if (lu[sel]) lu_cnt++;
        s_sc = sc[sel];
        s_ln = ln[sel];
        s_lv = lv[sel];
        @(negedge clk);
        if (lu[sel]) lu_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_unexpected_event: dut %0d accepted with no expectation queued", sel);
        end else begin
          e = exp_q.pop_front();
          check("score",   s_sc, e.score);
          check("lines",   s_ln, e.lines);
          check("level",   s_lv, e.level);
          check("busy",    busy, e.busy);
          check("levelup", lu_cnt, e.lvlups);
        end
      end
    end
  end

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL sb_timeout: %0d expectations left", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_clear(int d, int n, exp_t e);
    int t;
    exp_q.push_back(e);
    sel   = d;
    vld[d] = 1'b1;
    nl[d]  = 3'(n);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rdy[d] && t < 400);
    @(posedge clk);
    #1;
    vld[d] = 1'b0;
    if (t >= 400) begin
      n_chk++;
      $display("FAIL accept_timeout: dut %0d ready stuck low", d);
    end
    wait_drain();
  endtask

  initial begin
    exp_t e;
    int   s;
    for (int i = 0; i < 3; i++) begin
      ng[i] = 1'b0; vld[i] = 1'b0; nl[i] = 3'd0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_score",   sc[0], 24'h0);
    check("rst_lines",   ln[0], 24'h0);
    check("rst_level",   lv[0], 24'h0);
    check("rst_ready",   rdy[0], 1'b1);
    check("rst_levelup", lu[0], 1'b0);
    check("rst_level2",  lv[1], 24'h2);
    check("rst_level99", lv[2], 24'h99);
    @(posedge clk); #1;

    // Level 0: n=0 no-op, nine single clears, then a double that crosses into level 1.
    e = '{24'h0, 24'h0, 24'h0, 0, 0};
    do_clear(0, 0, e);
    for (int k = 1; k <= 9; k++) begin
      e = '{to_bcd(40 * k), to_bcd(k), 24'h0, 2, 0};
      do_clear(0, 1, e);
    end
    e = '{24'h000460, 24'h000011, 24'h000001, 2, 1};
    do_clear(0, 2, e);
    e = '{24'h001060, 24'h000014, 24'h000001, 3, 0};
    do_clear(0, 3, e);
    e = '{24'h003460, 24'h000018, 24'h000001, 3, 0};
    do_clear(0, 7, e);

    // New game in IDLE forces ready low and clears counters.
    ng[0] = 1'b1;
    @(negedge clk);
    check("ng_ready_low", rdy[0], 1'b0);
    @(posedge clk); #1 ng[0] = 1'b0;
    @(negedge clk);
    check("ng_idle_score", sc[0], 24'h0);
    check("ng_idle_level", lv[0], 24'h0);
    @(posedge clk); #1;

    // Start level 2: tetris scores 1200 x 3.
    e = '{24'h003600, 24'h000004, 24'h000002, 4, 0};
    do_clear(1, 4, e);

    // New game during the second SCORE cycle with valid still asserted.
    exp_q.push_back('{24'h0, 24'h0, 24'h000002, 2, 0});
    sel    = 1;
    vld[1] = 1'b1;
    nl[1]  = 3'd4;
    @(negedge clk);
    @(posedge clk); #1;
    @(posedge clk); #1 ng[1] = 1'b1;
    @(posedge clk); #1 begin ng[1] = 1'b0; vld[1] = 1'b0; end
    wait_drain();
    repeat (3) @(negedge clk);
    check("ng_no_accept_score", sc[1], 24'h0);
    check("ng_no_accept_lines", ln[1], 24'h0);
    check("ng_ready_back",      rdy[1], 1'b1);
    @(posedge clk); #1;

    // Start level 99: tetris = 120000 each, ninth saturates.
    for (int k = 1; k <= 9; k++) begin
      s = 120000 * k;
      e = '{(s > 999999) ? 24'h999999 : to_bcd(s), to_bcd(4 * k), 24'h000099, 101, 0};
      do_clear(2, 4, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
